// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, branch condition codes and flag bit positions.
// Also provides the per-opcode flag write mask used by the flag register.
package cpu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OV     = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam int FLAG_V = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  // Arithmetic ops own all three flags; logic/shift ops only report zero.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB: m = 3'b111;
      OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB: m[FLAG_Z] = 1'b1;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Combinational branch condition evaluator over a {N,Z,V} flag vector.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] nf,
  input  logic [2:0] cond,
  output logic       taken
);

  logic n, z, v;

  assign n = nf[FLAG_N];
  assign z = nf[FLAG_Z];
  assign v = nf[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NE:     taken = ~z;
      CC_EQ:     taken = z;
      CC_GT:     taken = ~z & ~n;
      CC_LT:     taken = n;
      CC_GTE:    taken = z | ~n;
      CC_LTE:    taken = n | z;
      CC_OV:     taken = v;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural flag register with EX-stage bypass, branch resolution against the
// bypassed flags, and a saturating count of overflowing arithmetic updates.
module flag_cond_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic [2:0]       ex_flag,
  input  logic             br_valid,
  input  logic [3:0]       br_opcode,
  input  logic [2:0]       br_cond,
  output logic [2:0]       flags,
  output logic             br_resolved,
  output logic             br_taken,
  output logic [CNT_W-1:0] sat_count
);

  logic             upd;
  logic [2:0]       mask;
  logic [2:0]       nf;
  logic             is_arith;
  logic             sat_inc;
  logic             br_acc;
  logic             cond_taken;
  logic [CNT_W-1:0] sat_max;

  assign upd      = ex_valid & ~stall & ~flush;
  assign mask     = upd ? flag_mask(ex_opcode) : 3'b000;
  assign nf       = (flags & ~mask) | (ex_flag & mask);
  assign is_arith = (ex_opcode == OP_ADD) || (ex_opcode == OP_SUB);
  assign sat_inc  = upd & is_arith & ex_flag[FLAG_V];
  assign br_acc   = br_valid & ~stall & ~flush &
                    ((br_opcode == OP_B) || (br_opcode == OP_BR));
  assign sat_max  = '1;

  cond_eval u_cond_eval (
    .nf    (nf),
    .cond  (br_cond),
    .taken (cond_taken)
  );

  // nf already equals flags whenever no update is accepted, so it is the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags       <= 3'b000;
      sat_count   <= '0;
      br_resolved <= 1'b0;
      br_taken    <= 1'b0;
    end else begin
      flags       <= nf;
      br_resolved <= br_acc;
      br_taken    <= br_acc & cond_taken;
      if (sat_inc && (sat_count != sat_max))
        sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Downstream consumer of the 16-bit saturating adder's N/Z/V flag output.
- Holds the architectural flag register and decides which opcodes update which flags.
- Resolves conditional branches against the flags, bypassing any same-cycle EX flag write.
- Counts saturation events for debug.
- Sits between the EX stage (adder/ALU) and the fetch redirect logic.

Parameters:
- CNT_W, 8, width of the saturation-event counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  pipeline hold; freezes all state, no branch accepted
- flush  in  1  squash EX and ID contents this cycle
- ex_valid  in  1  an instruction in EX is presenting flags this cycle
- ex_opcode  in  4  opcode of the EX instruction
- ex_flag  in  3  {N,Z,V} from the adder; bit0=V, bit1=Z, bit2=N
- br_valid  in  1  a branch in ID requests resolution
- br_opcode  in  4  4'b1100 (B) or 4'b1101 (BR); any other value is ignored
- br_cond  in  3  condition code
- flags  out  3  current flag register {N,Z,V}
- br_resolved  out  1  one-cycle pulse: a branch was resolved
- br_taken  out  1  condition result; meaningful only while br_resolved=1
- sat_count  out  CNT_W  number of accepted updates with V=1

Behaviour:
- Reset (rst=1 at a clk edge):
  - flags=3'b000, br_resolved=0, br_taken=0, sat_count=0.
  - Reset overrides stall and flush.
- Flag update masks, applied when ex_valid & ~stall & ~flush:
  - ADD 4'b0000 and SUB 4'b0001: write N, Z and V.
  - XOR 0010, RED 0011, SLL 0100, SRA 0101, ROR 0110, PADDSB 0111: write Z only; N and V hold.
  - All other opcodes: no write.
  - The write is visible on flags the following cycle.
- Next-flags bypass (nf):
  - nf = flags with the masked ex_flag bits substituted, when the update above is active this cycle.
  - Otherwise nf = flags.
- Branch acceptance:
  - A branch is accepted when br_valid & ~stall & ~flush and br_opcode is B or BR.
  - Condition evaluated on nf:
    - 000 NE: ~Z
    - 001 EQ: Z
    - 010 GT: ~Z & ~N
    - 011 LT: N
    - 100 GTE: Z | ~N
    - 101 LTE: N | Z
    - 110 OV: V
    - 111 always taken
  - Registered result: at the next edge br_resolved=1 and br_taken=result. Latency is one cycle.
- br_resolved is a single-cycle pulse.
  - Any cycle without an accepted branch clears br_resolved and br_taken to 0 at the next edge.
- stall=1:
  - flags and sat_count hold.
  - br_resolved and br_taken clear to 0 at the next edge, so a pulse never repeats during a stall.
  - Inputs are ignored.
- flush=1 (and stall=0):
  - No flag write, no branch accepted, no count.
  - br_resolved and br_taken clear to 0 at the next edge.
- Simultaneous events:
  - Flush wins over stall for discarding inputs. In both cases state holds and the outputs clear.
  - A flag write and a branch acceptance in the same cycle are both performed; the branch sees the written values via nf.
- sat_count:
  - Increments by 1 on each accepted ADD/SUB update with ex_flag[0]=1.
  - Holds at all-ones; it does not wrap.
  - Z-only opcodes never count.
- Reset mid-resolution: a branch accepted in the cycle rst is asserted produces no pulse.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants: OP_ADD..OP_PADDSB, OP_B, OP_BR
  - condition-code constants: CC_NE..CC_UNCOND
  - flag bit indices: FLAG_V=0, FLAG_Z=1, FLAG_N=2
- One combinational sub-module, cond_eval (inputs nf[2:0] and cond[2:0]; output taken).
  - The top level holds the flag register, bypass mux, counter and output registers.

Test Plan:
- Reset, then ADD with ex_flag=3'b101 (N=1,V=1) -> flags=3'b101 next cycle; sat_count=1.
- flags=3'b101, then XOR with ex_flag=3'b010 -> flags=3'b111 (N and V held, Z set); sat_count unchanged.
- Same cycle: SUB with ex_flag=3'b010 and branch cond=001 (EQ) while the old Z=0 -> br_resolved=1, br_taken=1 one cycle later (bypass).
- Branch cond=010 (GT) with flags=3'b000 and stall=1 for 3 cycles, then released -> no pulse during the stall; a single pulse with br_taken=1 one cycle after release.
- ADD with V=1 and br_valid together under flush=1 -> flags unchanged, sat_count unchanged, br_resolved stays 0.
- 260 accepted ADDs with V=1 (CNT_W=8) -> sat_count reaches 255 and holds. Then rst=1 -> sat_count=0, flags=0.
